// File: rtl/seq_div_pkg.sv
// seq_div_pkg -- shared types and constants for the sequential restoring divider.
//   state_e          : divider FSM state (IDLE, RUN, DONE)
//   DEFAULT_WIDTH    : default operand width
//   DEFAULT_CNT_W    : iteration counter width for DEFAULT_WIDTH
//   cnt_width()      : iteration counter width, $clog2(width+1)
package seq_div_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;
  localparam int unsigned DEFAULT_CNT_W = $clog2(DEFAULT_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/div_shreg.sv
// div_shreg -- {A,Q} shift/restore register plus subtractor of the restoring divider.
// Ports:
//   clk, clr_n : clock, asynchronous active-low reset
//   clear      : synchronous clear of A, Q, D
//   load       : A <= 0, Q <= dvd, D <= dvs
//   step       : one shift-subtract-restore iteration
//   dvd, dvs   : dividend / divisor to load
//   q_cur      : current Q register
//   q_step     : Q after the iteration performed this cycle
//   r_step     : A[WIDTH-1:0] after the iteration performed this cycle
module div_shreg
  import seq_div_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             clear,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dvd,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] q_cur,
  output logic [WIDTH-1:0] q_step,
  output logic [WIDTH-1:0] r_step
);

  logic [WIDTH:0]   a_q, a_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;

  logic [WIDTH:0]   a_sh;
  logic [WIDTH:0]   diff;
  logic [WIDTH:0]   a_step;
  logic             q_bit;

  // diff[WIDTH] is the borrow: set when the shifted remainder is below D.
  always_comb begin
    a_sh   = (a_q << 1) | (WIDTH+1)'(q_q[WIDTH-1]);
    diff   = a_sh - {1'b0, d_q};
    q_bit  = ~diff[WIDTH];
    a_step = diff[WIDTH] ? a_sh : diff;
    q_step = (q_q << 1) | WIDTH'(q_bit);
    r_step = a_step[WIDTH-1:0];
  end

  always_comb begin
    a_d = a_q;
    q_d = q_q;
    d_d = d_q;
    if (clear) begin
      a_d = '0;
      q_d = '0;
      d_d = '0;
    end else if (load) begin
      a_d = '0;
      q_d = dvd;
      d_d = dvs;
    end else if (step) begin
      a_d = a_step;
      q_d = q_step;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      a_q <= '0;
      q_q <= '0;
      d_q <= '0;
    end else begin
      a_q <= a_d;
      q_q <= q_d;
      d_q <= d_d;
    end
  end

  assign q_cur = q_q;

endmodule

// File: rtl/seq_divider.sv
// seq_divider -- sequential unsigned restoring divider, WIDTH iterations per division.
// Ports:
//   clk, clr_n : clock, asynchronous active-low reset
//   start      : request, sampled only in IDLE (ignored while busy)
//   dvd, dvs   : dividend / divisor, sampled with start
//   quot, rem  : results, valid from done, held until the next accepted start
//   busy       : high from the accepting edge until back in IDLE
//   done       : one-cycle pulse marking valid results
//   dz         : divide-by-zero flag, held with results
// Optional feature macro SEQ_DIV_DZ_DETECT_EN: early completion on a zero divisor
// with dz=1. Without it dz is 0 and a zero divisor runs all iterations.
module seq_divider
  import seq_div_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dvd,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem,
  output logic             busy,
  output logic             done,
  output logic             dz
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;

  logic             sr_clear, sr_load, sr_step;
  logic [WIDTH-1:0] q_cur, q_step, r_step;
  logic             dz_hit;

`ifdef SEQ_DIV_DZ_DETECT_EN
  assign dz_hit = (dvs == '0);
`else
  assign dz_hit = 1'b0;
`endif

  div_shreg #(
    .WIDTH(WIDTH)
  ) u_shreg (
    .clk   (clk),
    .clr_n (clr_n),
    .clear (sr_clear),
    .load  (sr_load),
    .step  (sr_step),
    .dvd   (dvd),
    .dvs   (dvs),
    .q_cur (q_cur),
    .q_step(q_step),
    .r_step(r_step)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    quot_d   = quot_q;
    rem_d    = rem_q;
    dz_d     = dz_q;
    sr_clear = 1'b0;
    sr_load  = 1'b0;
    sr_step  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          // A zero divisor (when detected) spends one RUN cycle flagged by dz,
          // so done lands one edge after acceptance and busy spans two cycles.
          sr_load = 1'b1;
          cnt_d   = '0;
          dz_d    = dz_hit;
          state_d = RUN;
        end
      end
      RUN: begin
        if (dz_q) begin
          state_d = DONE;
          quot_d  = '1;
          rem_d   = q_cur;
        end else begin
          sr_step = 1'b1;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d = DONE;
            quot_d  = q_step;
            rem_d   = r_step;
          end
        end
      end
      DONE: begin
        sr_clear = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
    end
  end

  assign quot = quot_q;
  assign rem  = rem_q;
  assign busy = busy_q;
  assign done = done_q;
  assign dz   = dz_q;

endmodule
